// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : shared state encoding and sizing for the divider sequencer |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package div_pkg;

   localparam int DIV_N     = 8;
   localparam int DIV_CNT_W = 3;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LD_M    = 4'd1,
      ST_LD_Q    = 4'd2,
      ST_SHIFT   = 4'd3,
      ST_SUB     = 4'd4,
      ST_SETQ    = 4'd5,
      ST_RESTORE = 4'd6,
      ST_OUT_Q   = 4'd7,
      ST_OUT_A   = 4'd8,
      ST_DONE    = 4'd9
   } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_iter_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_iter_cnt : restoring-iteration counter, saturates at N-1         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_iter_cnt
   import div_pkg::*;
#(
   parameter int N     = DIV_N,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clr,
   input  logic inc,
   output logic last
);

   logic [CNT_W-1:0] cnt;

   // Never advances past N-1, so the count cannot wrap.
   always_ff @(posedge CLK) begin
      if (RESET || clr) begin
         cnt <= '0;
      end else if (inc && !last) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last = (cnt == CNT_W'(N - 1));

endmodule
`default_nettype wire

// File: rtl/div_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_ctrl_seq : control-strobe sequencer for the 8-bit restoring divider |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_ctrl_seq
   import div_pkg::*;
#(
   parameter int N     = DIV_N,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic CLK,
   input  logic RESET,
   input  logic start,
   input  logic sign,
   output logic c0,
   output logic c1,
   output logic c2,
   output logic c3,
   output logic c4,
   output logic c6,
   output logic c7,
   output logic c8,
   output logic busy,
   output logic done
);

   div_state_t state;
   logic       cnt_clr;
   logic       cnt_inc;
   logic       cnt_last;

   assign cnt_clr = (state == ST_LD_Q);
   assign cnt_inc = !cnt_last &&
                    (((state == ST_SETQ) && !sign) || (state == ST_RESTORE));

   div_iter_cnt #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .last  (cnt_last)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (start) state <= ST_LD_M;
            ST_LD_M:    state <= ST_LD_Q;
            ST_LD_Q:    state <= ST_SHIFT;
            ST_SHIFT:   state <= ST_SUB;
            ST_SUB:     state <= ST_SETQ;
            ST_SETQ: begin
               // A negative trial difference takes the restore detour first.
               if (sign)          state <= ST_RESTORE;
               else if (cnt_last) state <= ST_OUT_Q;
               else               state <= ST_SHIFT;
            end
            ST_RESTORE: state <= cnt_last ? ST_OUT_Q : ST_SHIFT;
            ST_OUT_Q:   state <= ST_OUT_A;
            ST_OUT_A:   state <= ST_DONE;
            ST_DONE:    state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   // Strobes are pure decodes of the state register.
   assign c0   = (state == ST_LD_M);
   assign c1   = (state == ST_LD_Q);
   assign c4   = (state == ST_SHIFT);
   assign c3   = (state == ST_SUB);
   assign c2   = (state == ST_SETQ);
   assign c7   = (state == ST_RESTORE);
   assign c6   = (state == ST_OUT_Q);
   assign c8   = (state == ST_OUT_A);
   assign done = (state == ST_DONE);
   assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_ctrl_seq : directed self-checking bench for div_ctrl_seq      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_div_ctrl_seq;
   import div_pkg::*;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   logic start = 1'b0;
   logic sign  = 1'b0;
   logic c0, c1, c2, c3, c4, c6, c7, c8, busy, done;

   int vectors     = 0;
   int miscompares = 0;

   div_ctrl_seq dut (
      .CLK   (CLK),
      .RESET (RESET),
      .start (start),
      .sign  (sign),
      .c0    (c0),
      .c1    (c1),
      .c2    (c2),
      .c3    (c3),
      .c4    (c4),
      .c6    (c6),
      .c7    (c7),
      .c8    (c8),
      .busy  (busy),
      .done  (done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic int strobe_code();
      if (c0)   return 0;
      if (c1)   return 1;
      if (c2)   return 2;
      if (c3)   return 3;
      if (c4)   return 4;
      if (c6)   return 6;
      if (c7)   return 7;
      if (c8)   return 8;
      if (done) return 9;
      return 15;
   endfunction

   // Per-cycle invariants
   logic mon_en    = 1'b0;
   logic prev_done = 1'b0;
   always @(negedge CLK) begin
      if (mon_en) begin
         chk("onehot", $countones({c0, c1, c2, c3, c4, c6, c7, c8, done}) <= 1, 1);
         chk("done_twice", int'(prev_done & done), 0);
         if (!busy) chk("idle_quiet", {c0, c1, c2, c3, c4, c6, c7, c8, done}, 0);
         prev_done = done;
      end
   end

   // Run results
   int         q_obs[$];
   int         q_exp[$];
   int         run_len, n_c0, n_c7;
   logic [7:0] rmask;
   bit         timed_out, aborted;

   // Reference restoring datapath (13 / 3)
   localparam logic [7:0] DIVIDEND = 8'd13;
   localparam logic [7:0] DIVISOR  = 8'd3;
   logic [8:0] mA;
   logic [7:0] mQ, mM;

   // mode 0: sign=0, mode 1: sign=1, mode 2: sign from datapath model
   task automatic run(input int mode, input bit pulse_start, input bit do_reset);
      int iter;
      int guard;
      int code;
      bit sg;
      q_obs.delete();
      q_exp.delete();
      q_exp.push_back(0);
      q_exp.push_back(1);
      run_len = 0; n_c0 = 0; n_c7 = 0; rmask = '0;
      timed_out = 0; aborted = 0; iter = 0; guard = 0;
      start = 1'b1;
      tick();
      forever begin
         start = 1'b0;
         sign  = (mode == 1) ? 1'b0 : 1'b1;   // junk outside SETQ
         code  = strobe_code();
         if (code != 15) q_obs.push_back(code);
         run_len++;
         if (c0) begin n_c0++; mA = '0; mM = DIVISOR; end
         if (c1) mQ = DIVIDEND;
         if (c4) begin
            {mA, mQ} = {mA, mQ} << 1;
            if (pulse_start && iter == 4) start = 1'b1;
         end
         if (c3) begin
            mA = mA - {1'b0, mM};
            if (do_reset && iter == 3) begin
               RESET = 1'b1;
               tick();
               aborted = 1;
               return;
            end
         end
         if (c2) begin
            sg    = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : mA[8];
            sign  = sg;
            mQ[0] = ~sg;
            q_exp.push_back(4);
            q_exp.push_back(3);
            q_exp.push_back(2);
            if (sg) q_exp.push_back(7);
            if (iter < 8) rmask[iter] = sg;
            iter++;
         end
         if (c7) begin n_c7++; mA = mA + {1'b0, mM}; end
         if (done) begin
            if (pulse_start) start = 1'b1;
            break;
         end
         guard++;
         if (guard > 60) begin timed_out = 1; break; end
         tick();
      end
      q_exp.push_back(6);
      q_exp.push_back(8);
      q_exp.push_back(9);
   endtask

   task automatic check_order(input string tag);
      int bad;
      int n;
      bad = 0;
      n = (q_obs.size() < q_exp.size()) ? q_obs.size() : q_exp.size();
      for (int i = 0; i < n; i++) if (q_obs[i] != q_exp[i]) bad++;
      chk({tag, "_order_len"}, q_obs.size(), q_exp.size());
      chk({tag, "_order"}, bad, 0);
      chk({tag, "_timeout"}, int'(timed_out), 0);
   endtask

   initial begin
      tick();
      tick();
      RESET  = 1'b0;
      mon_en = 1'b1;
      chk("reset_outs", {c0, c1, c2, c3, c4, c6, c7, c8, busy, done}, 0);
      tick();
      chk("idle_hold", int'(busy), 0);

      // All subtracts succeed: minimum-length run
      run(0, 1'b0, 1'b0);
      check_order("t1");
      chk("t1_len", run_len, 29);
      chk("t1_c0", n_c0, 1);
      chk("t1_c7", n_c7, 0);
      tick();
      chk("t1_busy_after", int'(busy), 0);

      // 13 / 3 driven by the datapath model
      run(2, 1'b0, 1'b0);
      check_order("t2");
      chk("t2_len", run_len, 36);
      chk("t2_rmask", rmask, 8'b1101_1111);
      chk("t2_c7", n_c7, 7);
      chk("t2_rem", mA, 1);
      chk("t2_quot", mQ, 4);
      tick();
      chk("t2_busy_after", int'(busy), 0);

      // Every subtract fails: maximum-length run
      run(1, 1'b0, 1'b0);
      check_order("t3");
      chk("t3_len", run_len, 37);
      chk("t3_c7", n_c7, 8);
      chk("t3_rmask", rmask, 8'hFF);
      tick();

      // start pulses while busy (iteration 4 and DONE) are ignored
      run(0, 1'b1, 1'b0);
      check_order("t4");
      chk("t4_len", run_len, 29);
      chk("t4_c0", n_c0, 1);
      tick();
      chk("t4_idle_busy", int'(busy), 0);
      chk("t4_idle_c0", int'(c0), 0);
      start = 1'b0;
      repeat (3) tick();
      chk("t4_no_rerun", int'(busy), 0);

      // Reset in the SUB cycle of iteration 3
      run(0, 1'b0, 1'b1);
      chk("t5_aborted", int'(aborted), 1);
      chk("t5_rst_outs", {c0, c1, c2, c3, c4, c6, c7, c8, busy, done}, 0);
      chk("t5_rst_state", int'(dut.state), int'(ST_IDLE));
      chk("t5_rst_cnt", int'(dut.u_cnt.cnt), 0);
      RESET = 1'b0;
      tick();
      run(0, 1'b0, 1'b0);
      check_order("t5");
      chk("t5_len", run_len, 29);
      chk("t5_c0", n_c0, 1);
      tick();

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
